// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and defaults.
// FSM state encoding, default queue depth, reset PC, word step.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_HALTED = 2'd2
  } fetch_state_t;

  localparam int DEF_DEPTH = 4;
  localparam int unsigned DEF_RESET_PC = 0;
  localparam int unsigned PC_INC = 1;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of {pc, word} entries.
// Ports: push/pop/flush controls, head entry out, occupancy count.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [AW-1:0]            push_pc,
  input  logic [DW-1:0]            push_word,
  output logic [AW-1:0]            head_pc,
  output logic [DW-1:0]            head_word,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] word_q [DEPTH];
  logic [AW-1:0] pc_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & ~empty;
  // a full queue may still accept when the head leaves this cycle
  assign do_push = push & (~full | do_pop);

  assign head_word = word_q[rd_ptr];
  assign head_pc = pc_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        word_q[wr_ptr] <= push_word;
        pc_q[wr_ptr] <= push_pc;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: memory reads into a prefetch queue.
// Ports: en/halt/redirect ctrl, mem re/rdy, instr valid/take, count.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   halt,
  input  logic                   redirect,
  input  logic [15:0]            redirect_addr,
  output logic                   mem_re,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_data_r,
  input  logic                   mem_rdy,
  output logic [DATA_W-1:0]      instr,
  output logic [ADDR_W-1:0]      instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_take,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  fetch_state_t      state_nx;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_nx;
  logic              in_halt;
  logic              flush;
  logic              push;
  logic              pop;
  logic              can_issue;
  logic [CW-1:0]     count_nx;

  assign in_halt = state == S_HALTED;
  assign mem_re = state == S_REQ;
  assign mem_addr = fetch_pc;
  assign instr_valid = count != '0;

  // a redirect kills this cycle's push and take
  assign flush = redirect & ~in_halt;
  assign push = mem_re & mem_rdy & ~redirect;
  assign pop = instr_valid & instr_take & ~redirect;

  // issue on next-cycle occupancy so a take frees a slot at once
  assign count_nx = flush ? '0
                  : count + CW'(push) - CW'(pop);
  assign can_issue = en & ~halt
                   & (count_nx < CW'(DEPTH));

  always_comb begin
    state_nx = state;
    pc_nx = fetch_pc;
    unique case (state)
      S_IDLE: begin
        if (can_issue) state_nx = S_REQ;
      end
      S_REQ: begin
        if (mem_rdy) begin
          pc_nx = fetch_pc + ADDR_W'(PC_INC);
          state_nx = can_issue ? S_REQ : S_IDLE;
        end
      end
      S_HALTED: begin
        state_nx = S_HALTED;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    if (redirect) begin
      pc_nx = ADDR_W'(redirect_addr);
      state_nx = S_IDLE;
    end
    if (halt || in_halt) state_nx = S_HALTED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nx;
      fetch_pc <= pc_nx;
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH),
    .AW(ADDR_W),
    .DW(DATA_W)
  ) u_queue (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(flush),
    .push_pc(fetch_pc),
    .push_word(mem_data_r),
    .head_pc(instr_pc),
    .head_word(instr),
    .count(count)
  );

endmodule
